// File: rtl/mem_packet_pkg.sv
// Memory packet field layout (default widths) and memory controller FSM encoding.
// Shared by unified_cache and main_memory_ctrl.
package mem_packet_pkg;
  localparam int MEM_PACKET_ADDR_POS_LO = 0;
  localparam int MEM_PACKET_ADDR_POS_HI = 31;
  localparam int MEM_PACKET_DATA_POS_LO = 32;
  localparam int MEM_PACKET_DATA_POS_HI = 159;
  localparam int MEM_PACKET_VALID_POS   = 160;
  localparam int MEM_PACKET_WRITE_POS   = 161;
  localparam int MEM_PACKET_TYPE_POS_LO = 162;
  localparam int MEM_PACKET_TYPE_POS_HI = 164;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WAIT,
    ST_RESPOND
  } mem_state_e;
endpackage

// File: rtl/mem_block_array.sv
// NUM_BLOCKS x BLOCK_W register file: synchronous write, combinational read, async clear.
module mem_block_array #(
  parameter int NUM_BLOCKS = 32,
  parameter int BLOCK_W    = 128,
  parameter int IDX_W      = $clog2(NUM_BLOCKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [BLOCK_W-1:0] wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [BLOCK_W-1:0] rd_data
);
  logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] blocks;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        blocks <= '0;
    else if (wr_en) blocks[wr_idx] <= wr_data;
  end

  assign rd_data = blocks[rd_idx];
endmodule

// File: rtl/main_memory_ctrl.sv
// Fixed-latency main memory behind unified_cache: one request at a time,
// valid/ack packet handshakes on both sides.
module main_memory_ctrl
  import mem_packet_pkg::*;
#(
  parameter int MEM_PACKET_WIDTH_IN_BITS = 165,
  parameter int ADDR_LEN_IN_BITS         = 32,
  parameter int BLOCK_SIZE_IN_BITS       = 128,
  parameter int NUM_BLOCKS               = 32,
  parameter int LATENCY                  = 4
) (
  input  logic                                clk_in,
  input  logic                                reset_in,
  input  logic [MEM_PACKET_WIDTH_IN_BITS-1:0] request_packet_in,
  output logic                                request_ack_out,
  output logic [MEM_PACKET_WIDTH_IN_BITS-1:0] response_packet_out,
  input  logic                                response_ack_in
);
  localparam int DLO    = ADDR_LEN_IN_BITS;
  localparam int DHI    = DLO + BLOCK_SIZE_IN_BITS - 1;
  localparam int VPOS   = DHI + 1;
  localparam int WPOS   = DHI + 2;
  localparam int OFFSET = $clog2(BLOCK_SIZE_IN_BITS / 8);
  localparam int IDX_W  = $clog2(NUM_BLOCKS);
  localparam int CNT_W  = $clog2(LATENCY + 1);

  mem_state_e                          state;
  logic [CNT_W-1:0]                    counter;
  logic [MEM_PACKET_WIDTH_IN_BITS-1:0] req_q, rsp_next;
  logic [IDX_W-1:0]                    idx;
  logic [BLOCK_SIZE_IN_BITS-1:0]       rd_data;
  logic                                done, wr_en;

  // Address sits at bit 0, so the block index is taken straight from the packet.
  assign idx   = req_q[OFFSET +: IDX_W];
  assign done  = (state == ST_WAIT) && (counter == '0);
  assign wr_en = done && req_q[WPOS];

  always_comb begin
    rsp_next             = req_q;
    rsp_next[VPOS]       = 1'b1;
    rsp_next[DHI:DLO]    = req_q[WPOS] ? '0 : rd_data;
  end

  mem_block_array #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .BLOCK_W    (BLOCK_SIZE_IN_BITS),
    .IDX_W      (IDX_W)
  ) u_blocks (
    .clk     (clk_in),
    .rst     (reset_in),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_data (req_q[DHI:DLO]),
    .rd_idx  (idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state               <= ST_IDLE;
      counter             <= '0;
      req_q               <= '0;
      request_ack_out     <= 1'b0;
      response_packet_out <= '0;
    end else begin
      case (state)
        ST_IDLE: if (request_packet_in[VPOS]) begin
          req_q           <= request_packet_in;
          request_ack_out <= 1'b1;
          state           <= ST_ACCEPT;
        end
        ST_ACCEPT: begin
          request_ack_out <= 1'b0;
          counter         <= CNT_W'(LATENCY - 1);
          state           <= ST_WAIT;
        end
        ST_WAIT: begin
          // Write commits in the block array on this same edge.
          if (done) begin
            response_packet_out <= rsp_next;
            state               <= ST_RESPOND;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        ST_RESPOND: if (response_ack_in) begin
          response_packet_out <= '0;
          state               <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench for main_memory_ctrl: LATENCY=4 instance for the main tests,
// LATENCY=1 instance for back-to-back requests.
module tb_main_memory_ctrl;
  import mem_packet_pkg::*;

  localparam int LAT0 = 4;
  localparam int LAT1 = 1;
  typedef logic [164:0] pkt_t;

  logic clk = 1'b0;
  logic rst;
  pkt_t req0, rsp0, req1, rsp1;
  logic ack0, rack0, ack1, rack1;

  int   n_chk = 0, n_fail = 0;
  int   ack_delay = 0;
  int   ack_cnt1 = 0;
  pkt_t q0[$], q1[$];
  logic [127:0] model0 [32];
  logic [127:0] model1 [32];

  always #5 clk = ~clk;

  main_memory_ctrl #(.LATENCY(LAT0)) u_dut0 (
    .clk_in(clk), .reset_in(rst), .request_packet_in(req0), .request_ack_out(ack0),
    .response_packet_out(rsp0), .response_ack_in(rack0));

  main_memory_ctrl #(.LATENCY(LAT1)) u_dut1 (
    .clk_in(clk), .reset_in(rst), .request_packet_in(req1), .request_ack_out(ack1),
    .response_packet_out(rsp1), .response_ack_in(rack1));

  task automatic chk(input string tag, input pkt_t got, input pkt_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic pkt_t pkt(logic [2:0] typ, logic wr, logic vld, logic [127:0] d, logic [31:0] a);
    return {typ, wr, vld, d, a};
  endfunction

  // Responder for instance 0: acks after ack_delay extra cycles, checks hold stability.
  initial begin
    int   hold;
    pkt_t held;
    rack0 = 1'b0;
    hold  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rack0 = 1'b0; hold = 0;
      end else if (rack0) begin
        rack0 = 1'b0;
      end else if (rsp0[MEM_PACKET_VALID_POS]) begin
        if (hold == 0) held = rsp0;
        else chk("rsp0_stable", rsp0, held);
        if (hold >= ack_delay) begin
          if (q0.size() == 0) chk("rsp0_unexpected", rsp0, '0);
          else chk("rsp0", rsp0, q0.pop_front());
          rack0 = 1'b1; hold = 0;
        end else hold++;
      end
    end
  end

  // Responder for instance 1: immediate ack; also counts request acks.
  initial begin
    rack1 = 1'b0;
    forever begin
      @(negedge clk);
      if (ack1) ack_cnt1++;
      if (rst || rack1) rack1 = 1'b0;
      else if (rsp1[MEM_PACKET_VALID_POS]) begin
        if (q1.size() == 0) chk("rsp1_unexpected", rsp1, '0);
        else chk("rsp1", rsp1, q1.pop_front());
        rack1 = 1'b1;
      end
    end
  end

  task automatic wait_ack0(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = ack0;
    end
    chk("ack0_seen", pktSeen(seen), pktSeen(1'b1));
  endtask

  function automatic pkt_t pktSeen(bit b);
    return pkt_t'(b);
  endfunction

  task automatic send0(input logic wr, input logic [2:0] typ, input logic [31:0] a,
                       input logic [127:0] d, input bit measure);
    pkt_t exp;
    bit   seen;
    int   n;
    exp = wr ? pkt(typ, 1'b1, 1'b1, '0, a) : pkt(typ, 1'b0, 1'b1, model0[a[8:4]], a);
    if (wr) model0[a[8:4]] = d;
    q0.push_back(exp);
    @(negedge clk);
    req0 = pkt(typ, wr, 1'b1, d, a);
    wait_ack0(seen);
    req0 = '0;
    @(negedge clk);
    chk("ack0_width", pkt_t'(ack0), '0);
    if (measure) begin
      n = 1;
      while (!rsp0[MEM_PACKET_VALID_POS] && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("latency", pkt_t'(n), pkt_t'(LAT0 + 1));
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", pkt_t'(q0.size() + q1.size()), '0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    pkt_t exp;
    bit   seen;
    int   n;
    rst  = 1'b1;
    req0 = '0;
    req1 = '0;
    for (int i = 0; i < 32; i++) begin model0[i] = '0; model1[i] = '0; end
    repeat (3) @(negedge clk);
    chk("rst_ack0", pkt_t'(ack0), '0);
    chk("rst_rsp0", rsp0, '0);
    chk("rst_ack1", pkt_t'(ack1), '0);
    chk("rst_rsp1", rsp1, '0);
    rst = 1'b0;

    // Read of cleared storage
    send0(1'b0, 3'd1, 32'h30, '0, 1'b1);
    drain();

    // Write then read back, type echoed
    send0(1'b1, 3'd2, 32'h30, 128'hDEAD_BEEF, 1'b1);
    send0(1'b0, 3'd5, 32'h30, '0, 1'b1);
    drain();

    // Delayed response ack; a request presented meanwhile is not accepted
    ack_delay = 7;
    send0(1'b0, 3'd3, 32'h30, '0, 1'b1);
    exp = pkt(3'd6, 1'b1, 1'b1, '0, 32'h40);
    model0[4] = 128'h1234;
    q0.push_back(exp);
    req0 = pkt(3'd6, 1'b1, 1'b1, 128'h1234, 32'h40);
    n = 0;
    while (rsp0[MEM_PACKET_VALID_POS] && n < 20) begin
      chk("no_ack_busy", pkt_t'(ack0), '0);
      @(negedge clk);
      n++;
    end
    chk("hold_cycles", pkt_t'(n), pkt_t'(8));
    wait_ack0(seen);
    req0 = '0;
    ack_delay = 0;
    drain();
    send0(1'b0, 3'd0, 32'h40, '0, 1'b0);
    drain();

    // Address wrap: 0x210 and 0x010 share index 1
    send0(1'b1, 3'd0, 32'h210, 128'h55, 1'b0);
    send0(1'b0, 3'd4, 32'h010, '0, 1'b1);
    drain();

    // Reset during WAIT of a write to index 2
    @(negedge clk);
    req0 = pkt(3'd0, 1'b1, 1'b1, 128'hABCD, 32'h20);
    wait_ack0(seen);
    req0 = '0;
    repeat (2) @(negedge clk);
    chk("in_wait_rsp", rsp0, '0);
    rst = 1'b1;
    #1;
    chk("midrst_ack0", pkt_t'(ack0), '0);
    chk("midrst_rsp0", rsp0, '0);
    for (int i = 0; i < 32; i++) begin model0[i] = '0; model1[i] = '0; end
    @(negedge clk);
    rst = 1'b0;
    send0(1'b0, 3'd0, 32'h20, '0, 1'b1);
    drain();

    // Back-to-back on the LATENCY=1 instance: re-present right after each ack
    ack_cnt1 = 0;
    for (int i = 0; i < 6; i++) begin
      logic        wr;
      logic [31:0] a;
      logic [127:0] d;
      wr = (i < 3);
      a  = 32'h40 + 32'(i % 3) * 32'h10;
      d  = 128'h100 + 128'(i);
      exp = wr ? pkt(3'(i), 1'b1, 1'b1, '0, a) : pkt(3'(i), 1'b0, 1'b1, model1[a[8:4]], a);
      if (wr) model1[a[8:4]] = d;
      q1.push_back(exp);
      req1 = pkt(3'(i), wr, 1'b1, d, a);
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        seen = ack1;
      end
      chk("b2b_ack_seen", pkt_t'(seen), pkt_t'(1'b1));
    end
    req1 = '0;
    drain();
    chk("b2b_ack_count", pkt_t'(ack_cnt1), pkt_t'(6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/main_memory_ctrl.md
# main_memory_ctrl

Synthesizable main-memory model that sits directly downstream of `unified_cache` on its memory port. It consumes the cache's outgoing memory request packets and returns read data or write completions after a fixed, parameterized latency. It serves one request at a time over valid/ack packet handshakes identical in shape to the cache's. It replaces the ad-hoc memory responder in unit benches and is the default memory for system-level simulation.

## Interface
- `MEM_PACKET_WIDTH_IN_BITS`, default 165: packet width, equal to `ADDR_LEN_IN_BITS + BLOCK_SIZE_IN_BITS + 5`.
- `ADDR_LEN_IN_BITS`, default 32: address field width.
- `BLOCK_SIZE_IN_BITS`, default 128: data field width, one cache block.
- `NUM_BLOCKS`, default 32: storage depth in blocks; must be a power of 2.
- `LATENCY`, default 4: WAIT cycles per request; must be ≥1.

Packet layout, LSB first:
- addr: `[ADDR_LEN-1:0]`
- data: next `BLOCK_SIZE_IN_BITS` bits
- valid: 1 bit
- write: 1 bit
- type: 3 bits, top of packet

Ports:
- `clk_in`  in  1  single clock, rising edge.
- `reset_in`  in  1  asynchronous, active-high reset.
- `request_packet_in`  in  `MEM_PACKET_WIDTH_IN_BITS`  request from the cache's `to_mem_packet_out`.
- `request_ack_out`  out  1  one-cycle accept pulse, to the cache's `to_mem_packet_ack_in`.
- `response_packet_out`  out  `MEM_PACKET_WIDTH_IN_BITS`  response to the cache's `from_mem_packet_in`.
- `response_ack_in`  in  1  consumer accept, from the cache's `from_mem_packet_ack_out`.

## Operation
- Block index = `addr[OFFSET +: log2(NUM_BLOCKS)]`, where `OFFSET = log2(BLOCK_SIZE_IN_BITS/8)` (4 by default). Higher address bits are ignored, so addresses wrap modulo storage.
- FSM states: IDLE → ACCEPT → WAIT → RESPOND → IDLE.
- **IDLE:** when `request_packet_in.valid=1`, capture the whole packet into a request register, set `request_ack_out<=1`, and go to ACCEPT.
- **ACCEPT:** `request_ack_out<=0`, `counter<=LATENCY-1`, go to WAIT. The request input is ignored in every state except IDLE.
- **WAIT:** if `counter==0`, go to RESPOND; otherwise decrement. Entering RESPOND performs the transaction on that same edge:
  - Write: `mem[idx] <= captured data`. Response = {type echoed, write=1, valid=1, data=0, addr echoed}.
  - Read: response = {type echoed, write=0, valid=1, data=mem[idx], addr echoed}.
- **RESPOND:** hold `response_packet_out` stable until `response_ack_in` is sampled 1. On that edge, `response_packet_out<=0` and go to IDLE.
- A write is committed before its response appears. A following read to the same index returns the new data.
- `response_ack_in` sampled outside RESPOND is ignored.

## Timing
- Reset values: `request_ack_out=0`, `response_packet_out=0`, state IDLE, counter 0, request register 0, all storage blocks 0.
- Reset asserted mid-operation aborts the transaction immediately. An in-flight write whose RESPOND edge has not occurred is not committed.
- Capture at edge E0. `request_ack_out` is high for exactly the cycle E0→E1.
- Response valid appears after edge E(LATENCY+1) and stays until the ack edge.
- Minimum request-to-request spacing is LATENCY+3 cycles: ack, WAIT, RESPOND with immediate ack, IDLE.
- The requester holds its packet until it sees the ack and drops it at the following edge. The block is out of IDLE by then, so it never double-accepts.

## Structure
- Shared package `mem_packet_pkg`, used by the cache as well:
  - field position constants `MEM_PACKET_ADDR_POS_LO/HI`, `DATA_POS_LO/HI`, `VALID_POS`, `WRITE_POS`, `TYPE_POS_LO/HI`;
  - FSM state encoding.
- One natural sub-module: `mem_block_array`, the NUM_BLOCKS×BLOCK_SIZE register file with synchronous write, combinational read, and async clear.

## Test plan
- **Reset:** assert reset → all outputs 0. A read of addr 0x30 returns data 0 after LATENCY+1 cycles, with ack pulse width 1.
- **Write then read:** write addr 0x30, data 0xDEAD_BEEF → write response with write=1 and addr 0x30. Then read addr 0x30 → data 0xDEAD_BEEF, type echoed.
- **Delayed response ack:** hold `response_ack_in=0` for 7 cycles → response stays stable. A new request presented meanwhile gets no ack until the block returns to IDLE.
- **Address wrap:** write addr 0x210 (index 1) with data 0x55, then read addr 0x010 → data 0x55.
- **Reset mid-WAIT:** assert reset during WAIT of a write to index 2 → outputs clear at once. A subsequent read of index 2 returns 0.
- **Back-to-back requests:** requester re-presents immediately after each ack with LATENCY=1 → exactly one ack per request and responses in order.
